// File: rtl/hsci_axil_pkg.sv
// ---------------------------------------------------------------------------
// hsci_axil_pkg
// Shared types and constants for the HSCI AXI4-Lite region slave:
//   axil_state_t  - transaction FSM states
//   RESP_OKAY / RESP_DECERR - AXI response codes
//   DECERR_RDATA  - read data returned for unmapped reads when decode errors
//                   are reported
//   idx_width()   - width of a region index for a given region count
// ---------------------------------------------------------------------------
package hsci_axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    WRESP,
    RWAIT,
    RRESP
  } axil_state_t;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [1:0]  RESP_DECERR  = 2'b11;
  localparam logic [31:0] DECERR_RDATA = 32'hDEAD_DEAD;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hsci_axil_addr_decode.sv
// ---------------------------------------------------------------------------
// hsci_axil_addr_decode
// Combinational window decoder. Each region i covers the byte range
// [base_i, base_i + size_i), compared one bit wider than the address so a
// window ending at the top of the address space does not wrap. When windows
// overlap the lowest region index wins. Address bits [1:0] are ignored.
// Ports:
//   i_addr  in   ADDR_WIDTH    byte address
//   o_hit   out  NUM_REGIONS   one-hot hit vector (all zero on a miss)
//   o_idx   out  IDX_W         index of the hit region
//   o_woff  out  WADDR_WIDTH   word offset into the hit region
//   o_miss  out  1             address lies outside every window
// ---------------------------------------------------------------------------
module hsci_axil_addr_decode
  import hsci_axil_pkg::*;
#(
  parameter int NUM_REGIONS = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int WADDR_WIDTH = 14,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {16'h0004, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_SIZE = {16'h7FFC, 16'h0004},
  localparam int IDX_W = idx_width(NUM_REGIONS)
) (
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  output logic [NUM_REGIONS-1:0] o_hit,
  output logic [IDX_W-1:0]       o_idx,
  output logic [WADDR_WIDTH-1:0] o_woff,
  output logic                   o_miss
);

  logic [ADDR_WIDTH-1:0]  w_addr;
  logic [NUM_REGIONS-1:0] w_in;
  logic [WADDR_WIDTH-1:0] w_off [NUM_REGIONS];

  assign w_addr = {i_addr[ADDR_WIDTH-1:2], 2'b00};

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_win
    logic [ADDR_WIDTH:0]   w_a;
    logic [ADDR_WIDTH:0]   w_lo;
    logic [ADDR_WIDTH:0]   w_hi;
    logic [ADDR_WIDTH-1:0] w_diff;

    assign w_a     = {1'b0, w_addr};
    assign w_lo    = {1'b0, REGION_BASE[g*ADDR_WIDTH +: ADDR_WIDTH]};
    assign w_hi    = w_lo + {1'b0, REGION_SIZE[g*ADDR_WIDTH +: ADDR_WIDTH]};
    assign w_in[g] = (w_a >= w_lo) && (w_a < w_hi);
    assign w_diff  = w_addr - REGION_BASE[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_off[g] = WADDR_WIDTH'(w_diff >> 2);
  end

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    o_hit  = '0;
    o_idx  = '0;
    o_woff = '0;
    o_miss = 1'b1;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (w_in[i]) begin
        o_hit    = '0;
        o_hit[i] = 1'b1;
        o_idx    = IDX_W'(i);
        o_woff   = w_off[i];
        o_miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hsci_axil_region_slave.sv
// ---------------------------------------------------------------------------
// hsci_axil_region_slave
// AXI4-Lite slave front end for the HSCI master. Every access is decoded to
// one of NUM_REGIONS address windows; the slave then drives a shared
// word-address / write-data bus with one-hot per-region write or read
// strobes, waits RD_LATENCY cycles for read data and returns it on R.
// Reads and writes are arbitrated round-robin, starting with write.
// Configuration macro: HSCI_AXIL_DECERR_EN
//   defined   - unmapped accesses answer DECERR, reads return 32'hDEADDEAD
//   undefined - unmapped writes are dropped with OKAY, reads return 0 / OKAY
//   In both cases no region strobe fires and the timing is identical.
// Ports:
//   i_axi_clk, i_axi_reset         clock, asynchronous active-high reset
//   i_axi_aw*/o_axi_awready        write address channel
//   i_axi_w*/o_axi_wready          write data channel
//   o_axi_b*/i_axi_bready          write response channel
//   i_axi_ar*/o_axi_arready        read address channel
//   o_axi_r*/i_axi_rready          read data channel
//   o_reg_addr   WADDR_WIDTH       word offset into the selected region
//   o_reg_wdata  32                write data
//   o_reg_wstrb  4                 write byte enables
//   o_reg_wr_en  NUM_REGIONS       one-hot single-cycle write strobe
//   o_reg_rd_en  NUM_REGIONS       one-hot single-cycle read strobe
//   i_reg_rdata  32*NUM_REGIONS    per-region read data, region 0 in LSBs
// ---------------------------------------------------------------------------
module hsci_axil_region_slave
  import hsci_axil_pkg::*;
#(
  parameter int NUM_REGIONS = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int WADDR_WIDTH = 14,
  parameter int RD_LATENCY  = 2,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {16'h0004, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_SIZE = {16'h7FFC, 16'h0004}
) (
  input  logic                      i_axi_clk,
  input  logic                      i_axi_reset,
  input  logic [ADDR_WIDTH-1:0]     i_axi_awaddr,
  input  logic                      i_axi_awvalid,
  output logic                      o_axi_awready,
  input  logic [31:0]               i_axi_wdata,
  input  logic [3:0]                i_axi_wstrb,
  input  logic                      i_axi_wvalid,
  output logic                      o_axi_wready,
  output logic [1:0]                o_axi_bresp,
  output logic                      o_axi_bvalid,
  input  logic                      i_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     i_axi_araddr,
  input  logic                      i_axi_arvalid,
  output logic                      o_axi_arready,
  output logic [31:0]               o_axi_rdata,
  output logic [1:0]                o_axi_rresp,
  output logic                      o_axi_rvalid,
  input  logic                      i_axi_rready,
  output logic [WADDR_WIDTH-1:0]    o_reg_addr,
  output logic [31:0]               o_reg_wdata,
  output logic [3:0]                o_reg_wstrb,
  output logic [NUM_REGIONS-1:0]    o_reg_wr_en,
  output logic [NUM_REGIONS-1:0]    o_reg_rd_en,
  input  logic [32*NUM_REGIONS-1:0] i_reg_rdata
);

  localparam int         IDX_W      = idx_width(NUM_REGIONS);
  localparam logic [3:0] RD_LAT_CNT = 4'(RD_LATENCY);

`ifdef HSCI_AXIL_DECERR_EN
  localparam logic [1:0]  MISS_RESP  = RESP_DECERR;
  localparam logic [31:0] MISS_RDATA = DECERR_RDATA;
`else
  localparam logic [1:0]  MISS_RESP  = RESP_OKAY;
  localparam logic [31:0] MISS_RDATA = 32'h0;
`endif

  axil_state_t r_state, w_state_nxt;

  logic                   r_prio_wr;
  logic [NUM_REGIONS-1:0] r_hit;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_miss;
  logic [3:0]             r_cnt;
  logic                   r_wacc;
  logic [WADDR_WIDTH-1:0] r_reg_addr;
  logic [31:0]            r_wdata;
  logic [3:0]             r_wstrb;
  logic [NUM_REGIONS-1:0] r_wr_en;
  logic [NUM_REGIONS-1:0] r_rd_en;
  logic [1:0]             r_bresp;
  logic [1:0]             r_rresp;
  logic [31:0]            r_rdata;

  logic                   w_gnt_wr;
  logic                   w_gnt_rd;
  logic [ADDR_WIDTH-1:0]  w_dec_addr;
  logic [NUM_REGIONS-1:0] w_hit;
  logic [IDX_W-1:0]       w_idx;
  logic [WADDR_WIDTH-1:0] w_woff;
  logic                   w_miss;
  logic                   w_awready;
  logic                   w_arready;
  logic                   w_wready;
  logic [31:0]            w_rdata [NUM_REGIONS];

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_rd
    assign w_rdata[g] = i_reg_rdata[g*32 +: 32];
  end

  // r_prio_wr names the channel favoured when both are pending; a lone
  // request is always granted and still flips the priority.
  assign w_gnt_wr   = i_axi_awvalid && (!i_axi_arvalid || r_prio_wr);
  assign w_gnt_rd   = i_axi_arvalid && !w_gnt_wr;
  assign w_dec_addr = w_gnt_wr ? i_axi_awaddr : i_axi_araddr;

  hsci_axil_addr_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WADDR_WIDTH (WADDR_WIDTH),
    .REGION_BASE (REGION_BASE),
    .REGION_SIZE (REGION_SIZE)
  ) u_decode (
    .i_addr (w_dec_addr),
    .o_hit  (w_hit),
    .o_idx  (w_idx),
    .o_woff (w_woff),
    .o_miss (w_miss)
  );

  always_ff @(posedge i_axi_clk or posedge i_axi_reset) begin
    if (i_axi_reset) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  // WDATA runs two cycles: accept W (wready high), then issue the strobe
  // cycle with wready low before moving on to the response.
  always_comb begin
    w_state_nxt = r_state;
    w_awready   = 1'b0;
    w_arready   = 1'b0;
    w_wready    = 1'b0;
    case (r_state)
      IDLE: begin
        w_awready = w_gnt_wr;
        w_arready = w_gnt_rd;
        if (w_gnt_wr)      w_state_nxt = WDATA;
        else if (w_gnt_rd) w_state_nxt = RWAIT;
      end
      WDATA: begin
        w_wready = !r_wacc;
        if (r_wacc) w_state_nxt = WRESP;
      end
      WRESP:   if (i_axi_bready)    w_state_nxt = IDLE;
      RWAIT:   if (r_cnt == 4'd0)   w_state_nxt = RRESP;
      RRESP:   if (i_axi_rready)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_axi_clk or posedge i_axi_reset) begin
    if (i_axi_reset) begin
      r_prio_wr  <= 1'b1;
      r_hit      <= '0;
      r_idx      <= '0;
      r_miss     <= 1'b0;
      r_cnt      <= '0;
      r_wacc     <= 1'b0;
      r_reg_addr <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wr_en    <= '0;
      r_rd_en    <= '0;
      r_bresp    <= RESP_OKAY;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
    end else begin
      r_wr_en <= '0;
      r_rd_en <= '0;
      case (r_state)
        IDLE: begin
          if (w_gnt_wr || w_gnt_rd) begin
            r_reg_addr <= w_woff;
            r_hit      <= w_hit;
            r_idx      <= w_idx;
            r_miss     <= w_miss;
            r_prio_wr  <= w_gnt_rd;
            r_wacc     <= 1'b0;
            // Counter starts with the read strobe; an unmapped read still
            // waits the full latency so timing matches a mapped one.
            r_cnt      <= RD_LAT_CNT;
            if (w_gnt_wr) begin
              r_bresp <= w_miss ? MISS_RESP : RESP_OKAY;
            end else begin
              r_rd_en <= w_hit;
              r_rresp <= w_miss ? MISS_RESP : RESP_OKAY;
            end
          end
        end
        WDATA: begin
          if (!r_wacc && i_axi_wvalid) begin
            r_wdata <= i_axi_wdata;
            r_wstrb <= i_axi_wstrb;
            r_wr_en <= r_hit;
            r_wacc  <= 1'b1;
          end
        end
        RWAIT: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          else               r_rdata <= r_miss ? MISS_RDATA : w_rdata[r_idx];
        end
        default: ;
      endcase
    end
  end

  assign o_axi_awready = w_awready;
  assign o_axi_arready = w_arready;
  assign o_axi_wready  = w_wready;
  assign o_axi_bvalid  = (r_state == WRESP);
  assign o_axi_bresp   = r_bresp;
  assign o_axi_rvalid  = (r_state == RRESP);
  assign o_axi_rresp   = r_rresp;
  assign o_axi_rdata   = r_rdata;
  assign o_reg_addr    = r_reg_addr;
  assign o_reg_wdata   = r_wdata;
  assign o_reg_wstrb   = r_wstrb;
  assign o_reg_wr_en   = r_wr_en;
  assign o_reg_rd_en   = r_rd_en;

endmodule

// File: tb/tb_hsci_axil_region_slave.sv
// ---------------------------------------------------------------------------
// tb_hsci_axil_region_slave
// Directed bench: a table of single transactions with hand-computed results,
// followed by sequences for arbitration, back-pressure and mid-read reset.
// Region model: region 0 returns 32'hCAFE0001 + offset, region 1 returns
// 32'hBEEF0000 ^ offset, both two cycles after the read strobe; the cycle in
// between shows a poison value.
// ---------------------------------------------------------------------------
module tb_hsci_axil_region_slave;

  localparam int RD_LAT = 2;

`ifdef HSCI_AXIL_DECERR_EN
  localparam logic [1:0]  MISS_RESP  = 2'b11;
  localparam logic [31:0] MISS_RDATA = 32'hDEADDEAD;
`else
  localparam logic [1:0]  MISS_RESP  = 2'b00;
  localparam logic [31:0] MISS_RDATA = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0;
  logic        bready = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, arready, wready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [13:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic [1:0]  reg_wr_en, reg_rd_en;
  logic [63:0] reg_rdata;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  hsci_axil_region_slave #(
    .NUM_REGIONS (2),
    .ADDR_WIDTH  (16),
    .WADDR_WIDTH (14),
    .RD_LATENCY  (RD_LAT),
    .REGION_BASE ({16'h0004, 16'h0000}),
    .REGION_SIZE ({16'h7FFC, 16'h0004})
  ) dut (
    .i_axi_clk     (clk),
    .i_axi_reset   (rst),
    .i_axi_awaddr  (awaddr),
    .i_axi_awvalid (awvalid),
    .o_axi_awready (awready),
    .i_axi_wdata   (wdata),
    .i_axi_wstrb   (wstrb),
    .i_axi_wvalid  (wvalid),
    .o_axi_wready  (wready),
    .o_axi_bresp   (bresp),
    .o_axi_bvalid  (bvalid),
    .i_axi_bready  (bready),
    .i_axi_araddr  (araddr),
    .i_axi_arvalid (arvalid),
    .o_axi_arready (arready),
    .o_axi_rdata   (rdata),
    .o_axi_rresp   (rresp),
    .o_axi_rvalid  (rvalid),
    .i_axi_rready  (rready),
    .o_reg_addr    (reg_addr),
    .o_reg_wdata   (reg_wdata),
    .o_reg_wstrb   (reg_wstrb),
    .o_reg_wr_en   (reg_wr_en),
    .o_reg_rd_en   (reg_rd_en),
    .i_reg_rdata   (reg_rdata)
  );

  // ---------------- region model ----------------
  function automatic logic [31:0] region_val(input int idx, input logic [13:0] off);
    return (idx == 0) ? (32'hCAFE0001 + {18'b0, off}) : (32'hBEEF0000 ^ {18'b0, off});
  endfunction

  logic [31:0] m_rdata [2];
  logic [13:0] m_addr  [2];
  logic [1:0]  m_vld;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_vld[i]   <= 1'b0;
        m_rdata[i] <= '0;
        m_addr[i]  <= '0;
      end else if (reg_rd_en[i]) begin
        m_vld[i]   <= 1'b1;
        m_addr[i]  <= reg_addr;
        m_rdata[i] <= 32'h0BAD0BAD;
      end else if (m_vld[i]) begin
        m_vld[i]   <= 1'b0;
        m_rdata[i] <= region_val(i, m_addr[i]);
      end
    end
  end

  assign reg_rdata = {m_rdata[1], m_rdata[0]};

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    bit          to;
    int          lat;
    int          pulses;
    logic [1:0]  en_or;
    logic [13:0] addr;
    logic [31:0] wdat;
    logic [3:0]  wstb;
    logic [1:0]  resp;
    logic [31:0] rdat;
  } res_t;

  // Waits (bounded) for the address handshake of the requested channel.
  task automatic addr_hs(input bit wr, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      #1;
      ok = wr ? awready : arready;
      tick();
      n++;
    end
    if (wr) awvalid = 1'b0;
    else    arvalid = 1'b0;
  endtask

  // One complete transaction; cycle 1 is the cycle after the address handshake.
  task automatic xfer(input bit wr, input logic [15:0] a, input logic [31:0] d,
                      input logic [3:0] s, output res_t r);
    bit ok;
    bit done;
    logic [1:0] en;
    r.to = 1'b0; r.lat = 0; r.pulses = 0; r.en_or = '0; r.addr = '0;
    r.wdat = '0; r.wstb = '0; r.resp = '0; r.rdat = '0;
    bready = 1'b1;
    rready = 1'b1;
    if (wr) begin awaddr = a; awvalid = 1'b1; end
    else    begin araddr = a; arvalid = 1'b1; end
    addr_hs(wr, ok);
    if (!ok) begin r.to = 1'b1; return; end
    if (wr) begin wdata = d; wstrb = s; wvalid = 1'b1; end
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      en = wr ? reg_wr_en : reg_rd_en;
      if (en != 2'b00) begin
        r.pulses++;
        r.en_or |= en;
        r.addr = reg_addr;
        r.wdat = reg_wdata;
        r.wstb = reg_wstrb;
      end
      if (wr ? bvalid : rvalid) begin
        r.lat  = c;
        r.resp = wr ? bresp : rresp;
        r.rdat = rdata;
        done   = 1'b1;
        tick();
      end else if (wr && wready) begin
        tick();
        wvalid = 1'b0;
      end else begin
        tick();
      end
    end
    if (!done) r.to = 1'b1;
    wvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if ((reg_wr_en | reg_rd_en) != 2'b00) r.pulses++;
      tick();
    end
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  en;
    logic [13:0] waddr;
    logic [31:0] rdat;
    logic [1:0]  resp;
  } vec_t;

  vec_t vecs [11];

  initial begin : main
    res_t r;
    bit ok;
    logic [31:0] hold;
    bit grants [$];
    int seen;

    vecs[0]  = '{1'b1, 16'h0010, 32'hA5A51234, 4'hF, 2'b10, 14'd3,      32'h0,        2'b00};
    vecs[1]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 2'b01, 14'd0,      32'hCAFE0001, 2'b00};
    vecs[2]  = '{1'b1, 16'h0000, 32'h11112222, 4'h3, 2'b01, 14'd0,      32'h0,        2'b00};
    vecs[3]  = '{1'b1, 16'h0004, 32'h33334444, 4'h0, 2'b10, 14'd0,      32'h0,        2'b00};
    vecs[4]  = '{1'b1, 16'h0008, 32'h55556666, 4'h5, 2'b10, 14'd1,      32'h0,        2'b00};
    vecs[5]  = '{1'b0, 16'h7FFC, 32'h0,        4'h0, 2'b10, 14'h1FFE,   32'hBEEF1FFE, 2'b00};
    vecs[6]  = '{1'b0, 16'h8000, 32'h0,        4'h0, 2'b00, 14'd0,      MISS_RDATA,   MISS_RESP};
    vecs[7]  = '{1'b0, 16'h9000, 32'h0,        4'h0, 2'b00, 14'd0,      MISS_RDATA,   MISS_RESP};
    vecs[8]  = '{1'b1, 16'h9000, 32'h77778888, 4'hF, 2'b00, 14'd0,      32'h0,        MISS_RESP};
    vecs[9]  = '{1'b0, 16'h0007, 32'h0,        4'h0, 2'b10, 14'd0,      32'hBEEF0000, 2'b00};
    vecs[10] = '{1'b0, 16'h0003, 32'h0,        4'h0, 2'b01, 14'd0,      32'hCAFE0001, 2'b00};

    // ---- reset state ----
    tick();
    tick();
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_wready",  32'(wready),  32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_resp",    32'({bresp, rresp}), 32'd0);
    chk("rst_rdata",   rdata, 32'd0);
    chk("rst_regbus",  {4'(reg_wr_en), 4'(reg_rd_en), 4'(reg_wstrb), 20'(reg_addr)}, 32'd0);
    chk("rst_wdata",   reg_wdata, 32'd0);
    rst = 1'b0;
    tick();

    // ---- table-driven single transactions ----
    for (int i = 0; i < 11; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, r);
      chk($sformatf("v%0d_timeout", i), 32'(r.to), 32'd0);
      chk($sformatf("v%0d_en", i), 32'(r.en_or), 32'(vecs[i].en));
      chk($sformatf("v%0d_pulses", i), 32'(r.pulses), (vecs[i].en != 2'b00) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_latency", i), 32'(r.lat), vecs[i].wr ? 32'd3 : 32'(RD_LAT + 2));
      chk($sformatf("v%0d_resp", i), 32'(r.resp), 32'(vecs[i].resp));
      if (vecs[i].en != 2'b00) chk($sformatf("v%0d_reg_addr", i), 32'(r.addr), 32'(vecs[i].waddr));
      if (vecs[i].wr && vecs[i].en != 2'b00) begin
        chk($sformatf("v%0d_wdata", i), r.wdat, vecs[i].data);
        chk($sformatf("v%0d_wstrb", i), 32'(r.wstb), 32'(vecs[i].strb));
      end
      if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), r.rdat, vecs[i].rdat);
    end

    // ---- arbitration: both channels always requesting ----
    awaddr = 16'h0010; araddr = 16'h0000;
    wdata = 32'h01020304; wstrb = 4'hF;
    awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    for (int n = 0; n < 60 && grants.size() < 4; n++) begin
      #1;
      if (awready) grants.push_back(1'b1);
      if (arready) grants.push_back(1'b0);
      tick();
    end
    awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("arb_count", 32'(grants.size()), 32'd4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      chk($sformatf("arb_grant%0d_is_write", k), 32'(grants[k]), (k % 2 == 0) ? 32'd1 : 32'd0);

    // ---- read back-pressure: rvalid/rdata held, no new address accepted ----
    rready = 1'b0;
    araddr = 16'h0000; arvalid = 1'b1;
    addr_hs(1'b0, ok);
    chk("rstall_ar_hs", 32'(ok), 32'd1);
    seen = 0;
    for (int n = 0; n < 20 && !rvalid; n++) begin tick(); seen++; end
    chk("rstall_rvalid", 32'(rvalid), 32'd1);
    hold = rdata;
    chk("rstall_rdata", hold, 32'hCAFE0001);
    awaddr = 16'h0010; araddr = 16'h0008; awvalid = 1'b1; arvalid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("rstall_ready_%0d", k), 32'({awready, arready}), 32'd0);
      chk($sformatf("rstall_hold_%0d", k), {31'(rvalid), 1'b0} | 32'(rdata != hold), 32'd2);
      tick();
    end
    awvalid = 1'b0; arvalid = 1'b0; rready = 1'b1;
    tick();
    chk("rstall_release", 32'(rvalid), 32'd0);

    // ---- write back-pressure ----
    bready = 1'b0;
    awaddr = 16'h0010; awvalid = 1'b1;
    addr_hs(1'b1, ok);
    chk("bstall_aw_hs", 32'(ok), 32'd1);
    wdata = 32'hDEAD0001; wstrb = 4'hF; wvalid = 1'b1;
    for (int n = 0; n < 20 && !bvalid; n++) begin
      if (wready) begin tick(); wvalid = 1'b0; end
      else tick();
    end
    wvalid = 1'b0;
    chk("bstall_bvalid", 32'(bvalid), 32'd1);
    araddr = 16'h0000; awaddr = 16'h0004; arvalid = 1'b1; awvalid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("bstall_ready_%0d", k), 32'({awready, arready, wready}), 32'd0);
      chk($sformatf("bstall_hold_%0d", k), 32'({bvalid, bresp}), 32'b100);
      tick();
    end
    awvalid = 1'b0; arvalid = 1'b0; bready = 1'b1;
    tick();
    chk("bstall_release", 32'(bvalid), 32'd0);

    // ---- asynchronous reset while waiting for read data ----
    araddr = 16'h0010; arvalid = 1'b1;
    addr_hs(1'b0, ok);
    chk("rrst_ar_hs", 32'(ok), 32'd1);
    tick();
    chk("rrst_before_addr", 32'(reg_addr), 32'd3);
    rst = 1'b1;
    #1;
    chk("rrst_async_addr", 32'(reg_addr), 32'd0);
    chk("rrst_async_rdata", rdata, 32'd0);
    chk("rrst_async_ctl", 32'({rvalid, bvalid, reg_rd_en, reg_wr_en, arready, awready}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if ((reg_rd_en | reg_wr_en) != 2'b00 || rvalid || bvalid) seen++;
      tick();
    end
    chk("rrst_quiet_after", 32'(seen), 32'd0);
    xfer(1'b0, 16'h0010, 32'h0, 4'h0, r);
    chk("rrst_next_en", 32'(r.en_or), 32'b10);
    chk("rrst_next_rdata", r.rdat, 32'hBEEF0003);
    chk("rrst_next_lat", 32'(r.lat), 32'(RD_LAT + 2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
    $fatal(1, "watchdog");
  end

endmodule
